// File: rtl/calc_pkg.sv
// Shared types, command codes and display constants for the keypad calculator.
package calc_pkg;

  localparam int NDIG_DEF = 8;
  localparam int W_DEF    = 27;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    CALC    = 3'd2,
    RESULT  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  localparam logic [3:0] CMD_ADD  = 4'b1010;
  localparam logic [3:0] CMD_SUB  = 4'b1011;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_IDLE = 4'b1101;
  localparam logic [3:0] CMD_EQ   = 4'b1110;
  localparam logic [3:0] CMD_CLR  = 4'b1111;

  localparam logic [1:0] STATUS_READY = 2'b00;
  localparam logic [1:0] STATUS_BUSY  = 2'b01;
  localparam logic [1:0] STATUS_ERROR = 2'b10;

  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'h3F;
      4'd1:    seg_digit = 7'h06;
      4'd2:    seg_digit = 7'h5B;
      4'd3:    seg_digit = 7'h4F;
      4'd4:    seg_digit = 7'h66;
      4'd5:    seg_digit = 7'h6D;
      4'd6:    seg_digit = 7'h7D;
      4'd7:    seg_digit = 7'h07;
      4'd8:    seg_digit = 7'h7F;
      4'd9:    seg_digit = 7'h6F;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  // Elaboration-time helper for decimal range limits.
  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/calc_if.sv
// Keypad-in / display-out bundle between the board wrapper and the calculator.
interface calc_if #(parameter int NDIG = calc_pkg::NDIG_DEF);
  logic [3:0] cmd;
  logic [6:0] displays [NDIG-1:0];
  logic [1:0] status;
  logic [2:0] EA;
  logic [2:0] PE;

  modport master (output cmd, input displays, input status, input EA, input PE);
  modport slave  (input cmd, output displays, output status, output EA, output PE);
endinterface

// File: rtl/bin2sevenseg.sv
// Binary magnitude plus sign to NDIG seven-segment digits: double-dabble,
// decode, leading-zero blanking and a minus sign left of the top digit.
module bin2sevenseg
  import calc_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NDIG = NDIG_DEF
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [6:0]   segs [NDIG-1:0]
);

  localparam int SW = 4*NDIG + W;

  logic [SW-1:0]     sr;
  logic [4*NDIG-1:0] bcd;
  int                msd;

  // BCD digits sit above the binary field and absorb one bit per shift.
  always_comb begin
    sr = {{(4*NDIG){1'b0}}, value};
    for (int i = 0; i < W; i++) begin
      for (int d = 0; d < NDIG; d++) begin
        if (sr[W + 4*d +: 4] >= 4'd5) sr[W + 4*d +: 4] = sr[W + 4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    bcd = sr[W +: 4*NDIG];
  end

  always_comb begin
    msd = 0;
    for (int k = 0; k < NDIG; k++) begin
      if (bcd[4*k +: 4] != 4'd0) msd = k;
    end
    for (int k = 0; k < NDIG; k++) begin
      if (k <= msd)                 segs[k] = seg_digit(bcd[4*k +: 4]);
      else if (neg && k == msd + 1) segs[k] = SEG_MINUS;
      else                          segs[k] = SEG_BLANK;
    end
  end

endmodule

// File: rtl/calculator_top.sv
// Keypad calculator: edge-detected key acceptance, two-operand entry FSM,
// single-cycle add/sub and a bit-serial shift-and-add multiplier.
module calculator_top
  import calc_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int W    = W_DEF
) (
  input  logic  clock,
  input  logic  reset,
  calc_if.slave bus
);

  localparam int WP = W + 1;
  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W + 1);

  localparam logic [WP-1:0] MAX_VAL   = WP'(pow10(NDIG) - 1);
  localparam logic [W2-1:0] MAX_ACC   = W2'(pow10(NDIG) - 1);
  localparam logic [W-1:0]  DIG_LIMIT = W'(pow10(NDIG - 1));
  localparam logic [CW-1:0] MUL_STEPS = CW'(W);

  state_t        state, next;
  op_t           op, key_op;
  logic [3:0]    prev_cmd;
  logic          key_ok, is_digit, is_op, is_eq, is_clr;
  logic [W-1:0]  digit_ext;
  logic [W-1:0]  a_val, b_val, result;
  logic          sign;
  logic [W2-1:0] acc, mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          a_ge_b, addsub_ovf, mul_done, mul_ovf;
  logic [WP-1:0] addsub;
  logic [W-1:0]  held_val, src_val;
  logic          held_neg, src_neg;
  logic [1:0]    status;
  logic [6:0]    num_segs [NDIG-1:0];

  // A key counts once, on the cycle it first differs from last cycle's code.
  assign key_ok    = (bus.cmd != prev_cmd) && (bus.cmd != CMD_IDLE);
  assign is_digit  = key_ok && (bus.cmd <= 4'd9);
  assign is_op     = key_ok && ((bus.cmd == CMD_ADD) || (bus.cmd == CMD_SUB) || (bus.cmd == CMD_MUL));
  assign is_eq     = key_ok && (bus.cmd == CMD_EQ);
  assign is_clr    = key_ok && (bus.cmd == CMD_CLR);
  assign digit_ext = W'(bus.cmd);

  always_comb begin
    case (bus.cmd[1:0])
      2'b10:   key_op = OP_ADD;
      2'b11:   key_op = OP_SUB;
      default: key_op = OP_MUL;
    endcase
  end

  assign a_ge_b     = (a_val >= b_val);
  assign addsub     = (op == OP_ADD) ? ({1'b0, a_val} + {1'b0, b_val})
                    : (a_ge_b ? {1'b0, a_val - b_val} : {1'b0, b_val - a_val});
  assign addsub_ovf = (addsub > MAX_VAL);
  assign mul_done   = (cnt == MUL_STEPS);
  assign mul_ovf    = (acc > MAX_ACC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ENTER_A;
    else        state <= next;
  end

  always_comb begin
    next   = state;
    status = STATUS_READY;
    case (state)
      CALC:    status = STATUS_BUSY;
      ERROR:   status = STATUS_ERROR;
      default: status = STATUS_READY;
    endcase
    if (!reset) begin
      next = ENTER_A;
    end else if (is_clr) begin
      next = ENTER_A;
    end else begin
      case (state)
        ENTER_A: if (is_op) next = ENTER_B;
        ENTER_B: if (is_eq) next = CALC;
        CALC: begin
          if (op != OP_MUL)  next = addsub_ovf ? ERROR : RESULT;
          else if (mul_done) next = mul_ovf ? ERROR : RESULT;
        end
        RESULT: begin
          if (is_digit)   next = ENTER_A;
          else if (is_op) next = ENTER_B;
        end
        ERROR:   next = ERROR;
        default: next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_cmd <= CMD_IDLE;
      a_val    <= '0;
      b_val    <= '0;
      result   <= '0;
      sign     <= 1'b0;
      op       <= OP_ADD;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      held_val <= '0;
      held_neg <= 1'b0;
    end else begin
      prev_cmd <= bus.cmd;
      if (state != CALC) begin
        held_val <= src_val;
        held_neg <= src_neg;
      end
      if (is_clr) begin
        a_val    <= '0;
        b_val    <= '0;
        result   <= '0;
        sign     <= 1'b0;
        op       <= OP_ADD;
        acc      <= '0;
        mcand    <= '0;
        mplier   <= '0;
        cnt      <= '0;
        held_val <= '0;
        held_neg <= 1'b0;
      end else begin
        case (state)
          ENTER_A: begin
            if (is_digit && (a_val < DIG_LIMIT)) a_val <= a_val * W'(10) + digit_ext;
            else if (is_op) begin
              op    <= key_op;
              b_val <= '0;
            end
          end
          ENTER_B: begin
            if (is_digit && (b_val < DIG_LIMIT)) b_val <= b_val * W'(10) + digit_ext;
            else if (is_op) op <= key_op;
            else if (is_eq) begin
              acc    <= '0;
              cnt    <= '0;
              mcand  <= W2'(a_val);
              mplier <= b_val;
            end
          end
          CALC: begin
            if (op != OP_MUL) begin
              result <= addsub[W-1:0];
              sign   <= (op == OP_SUB) && !a_ge_b;
            end else if (!mul_done) begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt + 1'b1;
            end else begin
              result <= acc[W-1:0];
              sign   <= 1'b0;
            end
          end
          RESULT: begin
            // Chaining continues from the magnitude; the sign is dropped.
            if (is_digit) begin
              a_val <= digit_ext;
              sign  <= 1'b0;
            end else if (is_op) begin
              a_val <= result;
              op    <= key_op;
              b_val <= '0;
              sign  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    src_val = held_val;
    src_neg = held_neg;
    case (state)
      ENTER_A: begin src_val = a_val;  src_neg = 1'b0; end
      ENTER_B: begin src_val = b_val;  src_neg = 1'b0; end
      RESULT:  begin src_val = result; src_neg = sign; end
      default: ;
    endcase
  end

  bin2sevenseg #(.W(W), .NDIG(NDIG)) u_conv (
    .value (src_val),
    .neg   (src_neg),
    .segs  (num_segs)
  );

  always_comb begin
    for (int k = 0; k < NDIG; k++) begin
      if (state == ERROR) bus.displays[k] = (k == 0) ? SEG_E : SEG_BLANK;
      else                bus.displays[k] = num_segs[k];
    end
  end

  assign bus.EA     = state;
  assign bus.PE     = next;
  assign bus.status = status;

endmodule

// File: tb/tb_calculator_top.sv
// Self-checking bench: spec vector table, hand corner cases, and random keys
// checked against a decimal-arithmetic reference model.
module tb_calculator_top;
  import calc_pkg::*;

  localparam int     NDIG = NDIG_DEF;
  localparam int     W    = W_DEF;
  localparam longint MAXV = 64'd99999999;
  localparam longint DLIM = 64'd10000000;

  typedef struct {
    logic [3:0] key;
    logic [2:0] st;
    logic [1:0] stat;
    logic [6:0] d1;
    logic [6:0] d0;
    int         calc;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  calc_if bus ();

  calculator_top dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int nCompared = 0;
  int nMismatched = 0;

  int     mState, mOp, mPendState, mCalcLen;
  longint mA, mB, mRes, mPendRes;
  bit     mNeg, mPendNeg;

  vec_t vecs [13];

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmpVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [55:0] expDisp();
    longint v;
    bit neg;
    int n;
    logic [55:0] r;
    r = '0;
    if (mState == 4) begin
      r[6:0] = 7'h79;
      return r;
    end
    case (mState)
      0:       begin v = mA;   neg = 1'b0; end
      1, 2:    begin v = mB;   neg = 1'b0; end
      default: begin v = mRes; neg = mNeg; end
    endcase
    n = 1;
    while (n < NDIG && v >= pow10(n)) n++;
    for (int k = 0; k < NDIG; k++) begin
      if (k < n)                r[7*k +: 7] = segOf(int'((v / pow10(k)) % 10));
      else if (neg && (k == n)) r[7*k +: 7] = 7'h40;
    end
    return r;
  endfunction

  function automatic logic [55:0] actDisp();
    logic [55:0] r;
    for (int k = 0; k < NDIG; k++) r[7*k +: 7] = bus.displays[k];
    return r;
  endfunction

  task automatic checkOutput(input string name);
    int expStat;
    expStat = (mState == 2) ? 1 : ((mState == 4) ? 2 : 0);
    cmpVal({name, ".EA"}, 64'(bus.EA), 64'(mState));
    cmpVal({name, ".status"}, 64'(bus.status), 64'(expStat));
    cmpVal({name, ".displays"}, 64'(actDisp()), 64'(expDisp()));
  endtask

  task automatic modelReset();
    mState = 0; mA = 0; mB = 0; mRes = 0; mNeg = 1'b0; mOp = 0;
  endtask

  task automatic startCalc();
    longint v;
    bit n;
    n = 1'b0;
    case (mOp)
      0: v = mA + mB;
      1: if (mA >= mB) v = mA - mB; else begin v = mB - mA; n = 1'b1; end
      default: v = mA * mB;
    endcase
    mCalcLen   = (mOp == 2) ? W + 1 : 1;
    mPendState = (v > MAXV) ? 4 : 3;
    mPendRes   = v;
    mPendNeg   = n;
    mState     = 2;
  endtask

  task automatic modelKey(input int k);
    bit isOp;
    isOp = (k >= 10 && k <= 12);
    if (k == 15) begin
      modelReset();
      return;
    end
    case (mState)
      0: begin
        if (k <= 9) begin
          if (mA < DLIM) mA = mA * 10 + k;
        end else if (isOp) begin
          mOp = k - 10; mB = 0; mState = 1;
        end
      end
      1: begin
        if (k <= 9) begin
          if (mB < DLIM) mB = mB * 10 + k;
        end else if (isOp) mOp = k - 10;
        else if (k == 14) startCalc();
      end
      3: begin
        if (k <= 9) begin
          mA = k; mNeg = 1'b0; mState = 0;
        end else if (isOp) begin
          mA = mRes; mNeg = 1'b0; mOp = k - 10; mB = 0; mState = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic waitCalc(input string name, input int expLen);
    int c;
    c = 0;
    while (bus.EA == 3'd2 && c < 200) begin
      c++;
      @(negedge clock);
    end
    cmpVal(name, 64'(c), 64'(expLen));
  endtask

  task automatic applyStimulus(input int k);
    bus.cmd = 4'(k);
    @(negedge clock);
    bus.cmd = CMD_IDLE;
    modelKey(k);
    if (mState == 2) begin
      checkOutput($sformatf("key%0d_busy", k));
      waitCalc($sformatf("key%0d_calc_len", k), mCalcLen);
      mState = mPendState;
      if (mState == 3) begin
        mRes = mPendRes;
        mNeg = mPendNeg;
      end
    end
    checkOutput($sformatf("key%0d", k));
    @(negedge clock);
  endtask

  initial begin
    logic [55:0] d;
    int r, k;

    vecs[0]  = '{4'd1,     3'd0, 2'b00, 7'h00, 7'h06, 0};
    vecs[1]  = '{4'd2,     3'd0, 2'b00, 7'h06, 7'h5B, 0};
    vecs[2]  = '{CMD_MUL,  3'd1, 2'b00, 7'h00, 7'h3F, 0};
    vecs[3]  = '{4'd3,     3'd1, 2'b00, 7'h00, 7'h4F, 0};
    vecs[4]  = '{CMD_EQ,   3'd3, 2'b00, 7'h4F, 7'h7D, W + 1};
    vecs[5]  = '{4'd5,     3'd0, 2'b00, 7'h00, 7'h6D, 0};
    vecs[6]  = '{CMD_SUB,  3'd1, 2'b00, 7'h00, 7'h3F, 0};
    vecs[7]  = '{4'd8,     3'd1, 2'b00, 7'h00, 7'h7F, 0};
    vecs[8]  = '{CMD_EQ,   3'd3, 2'b00, 7'h40, 7'h4F, 1};
    vecs[9]  = '{CMD_ADD,  3'd1, 2'b00, 7'h00, 7'h3F, 0};
    vecs[10] = '{4'd4,     3'd1, 2'b00, 7'h00, 7'h66, 0};
    vecs[11] = '{CMD_EQ,   3'd3, 2'b00, 7'h00, 7'h07, 1};
    vecs[12] = '{CMD_CLR,  3'd0, 2'b00, 7'h00, 7'h3F, 0};

    modelReset();
    reset   = 1'b0;
    bus.cmd = CMD_IDLE;
    repeat (3) @(negedge clock);
    cmpVal("pe_in_reset", 64'(bus.PE), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset");
    d = actDisp();
    cmpVal("reset_d0", 64'(d[6:0]), 64'h3F);
    cmpVal("reset_upper", 64'(d[55:7]), 64'd0);

    for (int i = 0; i < 13; i++) begin
      bus.cmd = vecs[i].key;
      @(negedge clock);
      bus.cmd = CMD_IDLE;
      if (vecs[i].calc > 0) waitCalc($sformatf("vec%0d_calc_len", i), vecs[i].calc);
      cmpVal($sformatf("vec%0d", i),
             64'({bus.EA, bus.status, bus.displays[1], bus.displays[0]}),
             64'({vecs[i].st, vecs[i].stat, vecs[i].d1, vecs[i].d0}));
      @(negedge clock);
    end
    modelReset();

    bus.cmd = 4'd9;
    repeat (50) @(negedge clock);
    bus.cmd = CMD_IDLE;
    modelKey(9);
    @(negedge clock);
    checkOutput("held9");
    applyStimulus(9);

    applyStimulus(15);
    applyStimulus(0);
    applyStimulus(11);
    repeat (7) applyStimulus(9);
    applyStimulus(14);

    applyStimulus(15);
    repeat (4) applyStimulus(9);
    applyStimulus(12);
    repeat (4) applyStimulus(9);
    applyStimulus(14);

    applyStimulus(15);
    applyStimulus(1);
    repeat (4) applyStimulus(0);
    applyStimulus(12);
    applyStimulus(1);
    repeat (4) applyStimulus(0);
    applyStimulus(14);

    applyStimulus(15);
    repeat (9) applyStimulus(9);
    applyStimulus(10);
    applyStimulus(1);
    applyStimulus(14);
    applyStimulus(5);
    applyStimulus(12);
    applyStimulus(14);
    applyStimulus(15);

    applyStimulus(5);
    applyStimulus(12);
    applyStimulus(7);
    bus.cmd = CMD_EQ;
    @(negedge clock);
    bus.cmd = CMD_IDLE;
    repeat (5) @(negedge clock);
    cmpVal("midcalc_busy", 64'(bus.status), 64'(STATUS_BUSY));
    bus.cmd = CMD_CLR;
    @(negedge clock);
    bus.cmd = CMD_IDLE;
    modelKey(15);
    checkOutput("midcalc_clear");
    @(negedge clock);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 72) k = 10 + $urandom_range(0, 2);
      else if (r < 86) k = 14;
      else             k = 15;
      applyStimulus(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
